// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, exception codes and shared helpers of the execute stage.
package alu_pkg;
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_NOR  = 6'h05;
    localparam logic [5:0] OP_SLT  = 6'h06;
    localparam logic [5:0] OP_SLTU = 6'h07;
    localparam logic [5:0] OP_SLL  = 6'h08;
    localparam logic [5:0] OP_SRL  = 6'h09;
    localparam logic [5:0] OP_SRA  = 6'h0A;
    localparam logic [5:0] OP_LUI  = 6'h0B;
    localparam logic [5:0] OP_BEQ  = 6'h10;
    localparam logic [5:0] OP_BNE  = 6'h11;
    localparam logic [5:0] OP_BLEZ = 6'h12;
    localparam logic [5:0] OP_BGTZ = 6'h13;
    localparam logic [5:0] OP_BLTZ = 6'h14;
    localparam logic [5:0] OP_BGEZ = 6'h15;
    localparam logic [5:0] OP_J    = 6'h16;
    localparam logic [5:0] OP_JAL  = 6'h17;
    localparam logic [5:0] OP_CLZ  = 6'h18;
    localparam logic [5:0] OP_CLO  = 6'h19;
    localparam logic [5:0] OP_JR   = 6'h1C;
    localparam logic [5:0] OP_JALR = 6'h1D;

    localparam logic [7:0] TRAP_STALL  = 8'h01;
    localparam logic [7:0] EXC_OVF     = 8'h02;
    localparam logic [7:0] EXC_ILLEGAL = 8'h04;

    // Highest set bit wins because the scan runs upward; 32 when v is zero.
    function automatic logic [5:0] lead_zeros(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++)
            if (v[i]) n = 6'(31 - i);
        return n;
    endfunction
endpackage

// File: rtl/alu_br_cond.sv
// alu_br_cond: condition flag for the conditional branch opcodes.
module alu_br_cond
    import alu_pkg::*;
(
    input  logic [5:0]  alu_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        cond
);
    logic rs_zero;

    always_comb begin
        rs_zero = (rs == 32'd0);
        cond = (alu_op == OP_BEQ)  ? (rs == rt) :
               (alu_op == OP_BNE)  ? (rs != rt) :
               (alu_op == OP_BLEZ) ? (rs[31] | rs_zero) :
               (alu_op == OP_BGTZ) ? (~rs[31] & ~rs_zero) :
               (alu_op == OP_BLTZ) ? rs[31] :
               (alu_op == OP_BGEZ) ? ~rs[31] : 1'b0;
    end
endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: execute-stage ALU and branch resolution, registered into EX/MEM.
// Optional CLZ/CLO ops are built when ALU_CLZ_EN is defined.
module pipe_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       alu_op,
    input  logic             check_overflow,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             squash,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] br_target,
    output logic             br_enable,
    input  logic [7:0]       exc_in,
    output logic [7:0]       exc_out
);
    logic [31:0] sum, diff, res, tgt, br_tgt, j_tgt;
    logic [31:0] result_d, result_q, br_target_d, br_target_q;
    logic [7:0]  exc_out_d, exc_out_q;
    logic        br_enable_d, br_enable_q;
    logic        cond, en, known, ovf, kill, trap;

    alu_br_cond u_cond (.alu_op(alu_op), .rs(rs_val), .rt(rt_val), .cond(cond));

    always_comb begin
        sum    = rs_val + rt_val;
        diff   = rs_val - rt_val;
        br_tgt = pc_next + (imm << 2);
        j_tgt  = {pc_next[31:28], imm[25:0], 2'b00};
        res    = '0;
        tgt    = '0;
        en     = 1'b0;
        known  = 1'b1;
        ovf    = 1'b0;
        case (alu_op)
            OP_ADD:  begin res = sum;  ovf = (rs_val[31] == rt_val[31]) && (sum[31] != rs_val[31]); end
            OP_SUB:  begin res = diff; ovf = (rs_val[31] != rt_val[31]) && (diff[31] != rs_val[31]); end
            OP_AND:  res = rs_val & rt_val;
            OP_OR:   res = rs_val | rt_val;
            OP_XOR:  res = rs_val ^ rt_val;
            OP_NOR:  res = ~(rs_val | rt_val);
            OP_SLT:  res = {31'd0, $signed(rs_val) < $signed(rt_val)};
            OP_SLTU: res = {31'd0, rs_val < rt_val};
            OP_SLL:  res = rt_val << rs_val[4:0];
            OP_SRL:  res = rt_val >> rs_val[4:0];
            OP_SRA:  res = $signed(rt_val) >>> rs_val[4:0];
            OP_LUI:  res = {rt_val[15:0], 16'h0};
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ:
                     begin tgt = br_tgt; en = cond; end
            OP_J:    begin tgt = j_tgt;  en = 1'b1; end
            OP_JAL:  begin tgt = j_tgt;  en = 1'b1; res = pc_next; end
            OP_JR:   begin tgt = rs_val; en = 1'b1; end
            OP_JALR: begin tgt = rs_val; en = 1'b1; res = pc_next; end
`ifdef ALU_CLZ_EN
            OP_CLZ:  res = {26'd0, lead_zeros(rs_val)};
            OP_CLO:  res = {26'd0, lead_zeros(~rs_val)};
`endif
            default: known = 1'b0;
        endcase
        kill        = squash | (exc_in != 8'h00) | ~known;
        trap        = check_overflow & ovf;
        result_d    = kill ? '0 : res;
        br_target_d = (kill | trap) ? '0 : tgt;
        br_enable_d = ~(kill | trap) & en;
        exc_out_d   = squash             ? TRAP_STALL :
                      (exc_in != 8'h00)  ? exc_in :
                      ~known             ? EXC_ILLEGAL :
                      trap               ? EXC_OVF : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            br_target_q <= '0;
            br_enable_q <= 1'b0;
            exc_out_q   <= '0;
        end else begin
            result_q    <= result_d;
            br_target_q <= br_target_d;
            br_enable_q <= br_enable_d;
            exc_out_q   <= exc_out_d;
        end
    end

    assign result    = result_q;
    assign br_target = br_target_q;
    assign br_enable = br_enable_q;
    assign exc_out   = exc_out_q;
endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: directed self-checking bench for pipe_alu (honours ALU_CLZ_EN).
module tb_pipe_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  alu_op = OP_ADD;
    logic        check_overflow = 1'b0;
    logic [31:0] pc_next = '0;
    logic        squash = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [31:0] imm = '0;
    logic [31:0] result, br_target;
    logic        br_enable;
    logic [7:0]  exc_in = '0;
    logic [7:0]  exc_out;
    int compared = 0;
    int mismatched = 0;

    pipe_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .check_overflow(check_overflow),
        .pc_next(pc_next), .squash(squash), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .result(result), .br_target(br_target), .br_enable(br_enable),
        .exc_in(exc_in), .exc_out(exc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc);
        alu_op = op; rs_val = a; rt_val = b; imm = im; pc_next = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(OP_ADD, 32'd5, 32'd3, 32'd0, 32'd0);
        rst = 1'b1;
        step();
        check("rst_result", result, 32'd0);
        check("rst_br_en", {31'd0, br_enable}, 32'd0);
        check("rst_exc", {24'd0, exc_out}, 32'd0);
        rst = 1'b0;
        step();
        check("add_result", result, 32'd8);
        check("add_exc", {24'd0, exc_out}, 32'd0);

        drive(OP_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0);
        check_overflow = 1'b1;
        step();
        check("ovf_exc", {24'd0, exc_out}, 32'h02);
        check("ovf_result", result, 32'h80000000);
        check_overflow = 1'b0;
        step();
        check("noovf_exc", {24'd0, exc_out}, 32'h00);
        check("noovf_result", result, 32'h80000000);

        drive(OP_SUB, 32'h80000000, 32'd1, 32'd0, 32'd0);
        check_overflow = 1'b1;
        step();
        check("subovf_exc", {24'd0, exc_out}, 32'h02);
        check("subovf_result", result, 32'h7FFFFFFF);
        check_overflow = 1'b0;

        drive(OP_BEQ, 32'd7, 32'd7, 32'hFFFFFFFE, 32'h3004);
        step();
        check("beq_en", {31'd0, br_enable}, 32'd1);
        check("beq_tgt", br_target, 32'h2FFC);
        check("beq_result", result, 32'd0);
        squash = 1'b1;
        exc_in = 8'h08;
        step();
        check("squash_en", {31'd0, br_enable}, 32'd0);
        check("squash_exc", {24'd0, exc_out}, 32'h01);
        check("squash_tgt", br_target, 32'd0);
        squash = 1'b0;
        exc_in = 8'h00;

        drive(OP_BNE, 32'd7, 32'd7, 32'd4, 32'h3004);
        step();
        check("bne_en", {31'd0, br_enable}, 32'd0);
        drive(OP_BLEZ, 32'd0, 32'd0, 32'd1, 32'h1000);
        step();
        check("blez_en", {31'd0, br_enable}, 32'd1);
        check("blez_tgt", br_target, 32'h1004);
        drive(OP_BGTZ, 32'd0, 32'd0, 32'd1, 32'h1000);
        step();
        check("bgtz_en", {31'd0, br_enable}, 32'd0);

        drive(OP_JAL, 32'd0, 32'd0, 32'h00000C00, 32'h3008);
        step();
        check("jal_tgt", br_target, 32'h3000);
        check("jal_result", result, 32'h3008);
        check("jal_en", {31'd0, br_enable}, 32'd1);
        drive(OP_JR, 32'h00001234, 32'd0, 32'd0, 32'h3008);
        step();
        check("jr_tgt", br_target, 32'h1234);
        check("jr_result", result, 32'd0);

        drive(OP_SRA, 32'd4, 32'h80000000, 32'd0, 32'd0);
        step();
        check("sra", result, 32'hF8000000);
        check("sra_tgt", br_target, 32'd0);
        drive(OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        step();
        check("slt", result, 32'd1);
        drive(OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
        step();
        check("sltu", result, 32'd0);
        drive(OP_LUI, 32'd0, 32'h0001ABCD, 32'd0, 32'd0);
        step();
        check("lui", result, 32'hABCD0000);

        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0);
        exc_in = 8'h08;
        step();
        check("excin_exc", {24'd0, exc_out}, 32'h08);
        check("excin_en", {31'd0, br_enable}, 32'd0);
        check("excin_result", result, 32'd0);
        exc_in = 8'h00;

        drive(6'h3F, 32'd1, 32'd2, 32'd0, 32'd0);
        step();
        check("illegal_exc", {24'd0, exc_out}, 32'h04);

        drive(OP_CLZ, 32'h00010000, 32'd0, 32'd0, 32'd0);
        step();
`ifdef ALU_CLZ_EN
        check("clz_result", result, 32'd15);
        check("clz_exc", {24'd0, exc_out}, 32'h00);
`else
        check("clz_illegal", {24'd0, exc_out}, 32'h04);
`endif

        drive(OP_J, 32'd0, 32'd0, 32'd8, 32'h3000);
        rst = 1'b1;
        step();
        check("rst2_en", {31'd0, br_enable}, 32'd0);
        check("rst2_tgt", br_target, 32'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
